// File: rtl/rotate_frame_ctrl_if.sv
// rtl/rotate_frame_ctrl_if.sv - rotator and source/destination SRAM signals of the frame sequencer
// master = sequencer side, slave = rotator/SRAM side.
interface rotate_frame_ctrl_if #(
  parameter int IMAGE_COOR_BIT = 6,
  parameter int ANG_WIDTH      = 9,
  parameter int PIXEL_WIDTH    = 24,
  parameter int ADDR_WIDTH     = 12
);
  logic                          o_rot_start;
  logic [IMAGE_COOR_BIT-1:0]     o_rot_H;
  logic [IMAGE_COOR_BIT-1:0]     o_rot_V;
  logic signed [ANG_WIDTH-1:0]   o_rot_angle;
  logic [IMAGE_COOR_BIT-1:0]     i_rot_H;
  logic [IMAGE_COOR_BIT-1:0]     i_rot_V;
  logic                          i_rot_oor;
  logic                          i_rot_done;
  logic                          o_src_rd;
  logic [ADDR_WIDTH-1:0]         o_src_addr;
  logic [PIXEL_WIDTH-1:0]        i_src_data;
  logic                          o_dst_we;
  logic [ADDR_WIDTH-1:0]         o_dst_addr;
  logic [PIXEL_WIDTH-1:0]        o_dst_data;

  modport master (
    output o_rot_start, o_rot_H, o_rot_V, o_rot_angle,
    input  i_rot_H, i_rot_V, i_rot_oor, i_rot_done,
    output o_src_rd, o_src_addr,
    input  i_src_data,
    output o_dst_we, o_dst_addr, o_dst_data
  );

  modport slave (
    input  o_rot_start, o_rot_H, o_rot_V, o_rot_angle,
    output i_rot_H, i_rot_V, i_rot_oor, i_rot_done,
    input  o_src_rd, o_src_addr,
    output i_src_data,
    input  o_dst_we, o_dst_addr, o_dst_data
  );
endinterface

// File: rtl/rotate_frame_ctrl.sv
// rtl/rotate_frame_ctrl.sv - raster-order inverse-mapping sequencer for the pixel rotator
// One rotation, optional source read, one destination write per destination pixel.
module rotate_frame_ctrl #(
  parameter int IMAGE_SIZE     = 60,
  parameter int IMAGE_COOR_BIT = 6,
  parameter int ANG_WIDTH      = 9,
  parameter int PIXEL_WIDTH    = 24,
  parameter int ADDR_WIDTH     = 12,
  parameter logic [PIXEL_WIDTH-1:0] BG_COLOR = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic signed [ANG_WIDTH-1:0] i_angle,
  output logic                        o_busy,
  output logic                        o_done,
  rotate_frame_ctrl_if.master         bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROT, S_WAIT, S_READ, S_DATA, S_WRITE, S_DONE
  } state_t;

  localparam logic [IMAGE_COOR_BIT-1:0] LAST   = IMAGE_COOR_BIT'(IMAGE_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0]     SIZE_A = ADDR_WIDTH'(IMAGE_SIZE);

  state_t                      state_q, state_d;
  logic [IMAGE_COOR_BIT-1:0]   h_q, h_d, v_q, v_d;
  logic signed [ANG_WIDTH-1:0] ang_q;
  logic                        armed_q;
  logic                        busy_q, done_q;
  logic                        rot_start_q, src_rd_q, dst_we_q;
  logic [ADDR_WIDTH-1:0]       src_addr_q, dst_addr_q;
  logic [PIXEL_WIDTH-1:0]      dst_data_q;
  logic                        start_ok;

  // armed_q keeps a start that coincides with reset release from launching a frame
  assign start_ok = armed_q && i_start;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          h_d     = '0;
          v_d     = '0;
          state_d = S_ROT;
        end
      end
      S_ROT:  state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_rot_done) begin
          state_d = bus.i_rot_oor ? S_WRITE : S_READ;
        end
      end
      S_READ: state_d = S_DATA;
      S_DATA: state_d = S_WRITE;
      S_WRITE: begin
        if (h_q == LAST) begin
          h_d = '0;
          v_d = v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
        state_d = (h_q == LAST && v_q == LAST) ? S_DONE : S_ROT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      v_q         <= '0;
      ang_q       <= '0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rot_start_q <= 1'b0;
      src_rd_q    <= 1'b0;
      dst_we_q    <= 1'b0;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      dst_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      armed_q     <= 1'b1;
      // strobes are registered copies of the state being entered
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      rot_start_q <= (state_d == S_ROT);
      src_rd_q    <= (state_d == S_READ);
      dst_we_q    <= (state_d == S_WRITE);
      if (state_q == S_IDLE && start_ok) begin
        ang_q <= -i_angle;
      end
      if (state_q == S_WAIT && bus.i_rot_done) begin
        src_addr_q <= ADDR_WIDTH'(bus.i_rot_V) * SIZE_A + ADDR_WIDTH'(bus.i_rot_H);
        if (bus.i_rot_oor) begin
          dst_data_q <= BG_COLOR;
        end
      end
      if (state_q == S_DATA) begin
        dst_data_q <= bus.i_src_data;
      end
      if (state_d == S_WRITE) begin
        dst_addr_q <= ADDR_WIDTH'(v_q) * SIZE_A + ADDR_WIDTH'(h_q);
      end
    end
  end

  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign bus.o_rot_start = rot_start_q;
  assign bus.o_rot_H     = h_q;
  assign bus.o_rot_V     = v_q;
  assign bus.o_rot_angle = ang_q;
  assign bus.o_src_rd    = src_rd_q;
  assign bus.o_src_addr  = src_addr_q;
  assign bus.o_dst_we    = dst_we_q;
  assign bus.o_dst_addr  = dst_addr_q;
  assign bus.o_dst_data  = dst_data_q;

endmodule
